// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter and its result FIFO.
// Holds the arbiter state encoding and the register-address width.
package wb_port_arbiter_pkg;

   localparam int REG_AW = 5;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_FORCE  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order FIFO of {rd, data} pairs holding multicycle-unit results until they win
// the register-file write port. Occupancy is registered so full/empty are glitch-free.
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_WITDH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [REG_AW-1:0]          i_push_rd,
   input  logic [DATA_WITDH-1:0]      i_push_data,
   input  logic                       i_pop,
   output logic [REG_AW-1:0]          o_head_rd,
   output logic [DATA_WITDH-1:0]      o_head_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = REG_AW + DATA_WITDH;

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full      = (r_count == CW'(DEPTH));
   assign o_empty     = (r_count == '0);
   assign o_count     = r_count;
   assign w_do_push   = i_push && !o_full;
   assign w_do_pop    = i_pop && !o_empty;
   assign o_head_rd   = r_mem[r_rd_ptr][EW-1:DATA_WITDH];
   assign o_head_data = r_mem[r_rd_ptr][DATA_WITDH-1:0];

   // NOTE: storage is deliberately not reset; clearing the pointers and count is
   // enough to discard entries, and a reset-free array maps onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= {i_push_rd, i_push_data};
   end

   // Power-of-two depth makes the pointers wrap naturally modulo DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order pipeline and
// buffered multicycle results, forcing a one-cycle pipeline stall when the buffer starves.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_WITDH = 32,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pipe_we,
   input  logic [REG_AW-1:0]       pipe_rd,
   input  logic [DATA_WITDH-1:0]   pipe_data,
   input  logic                    mc_valid,
   output logic                    mc_ready,
   input  logic [REG_AW-1:0]       mc_rd,
   input  logic [DATA_WITDH-1:0]   mc_data,
   output logic                    pipe_stall,
   output logic                    reg_wew,
   output logic [REG_AW-1:0]       rdw,
   output logic [DATA_WITDH-1:0]   result,
   output logic [$clog2(DEPTH):0]  buf_count
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP  = SW'(STARVE_MAX);
   localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

   arb_state_t              r_state;
   arb_state_t              w_next_state;
   logic [SW-1:0]           r_starve;
   logic                    r_pipe_stall;
   logic                    r_reg_wew;
   logic [REG_AW-1:0]       r_rdw;
   logic [DATA_WITDH-1:0]   r_result;

   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_grant_pipe;
   logic                    w_buf_loses;
   logic [REG_AW-1:0]       w_head_rd;
   logic [DATA_WITDH-1:0]   w_head_data;

   // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
   assign mc_ready = !w_full;
   assign w_push   = mc_valid && mc_ready;

   wb_result_fifo #(
      .DATA_WITDH (DATA_WITDH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_rd   (mc_rd),
      .i_push_data (mc_data),
      .i_pop       (w_pop),
      .o_head_rd   (w_head_rd),
      .o_head_data (w_head_data),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (buf_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_NORMAL;
      else     r_state <= w_next_state;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_NORMAL: if (w_buf_loses && r_starve >= STARVE_LAST) w_next_state = ST_FORCE;
         ST_FORCE:  w_next_state = ST_NORMAL;
         default:   w_next_state = ST_NORMAL;
      endcase
   end

   always_comb begin
      w_grant_pipe = 1'b0;
      w_pop        = 1'b0;
      w_buf_loses  = 1'b0;
      if (r_state == ST_FORCE) begin
         w_pop = !w_empty;
      end else if (pipe_we) begin
         w_grant_pipe = 1'b1;
         w_buf_loses  = !w_empty;
      end else begin
         w_pop = !w_empty;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve     <= '0;
         r_pipe_stall <= 1'b0;
         r_reg_wew    <= 1'b0;
         r_rdw        <= '0;
         r_result     <= '0;
      end else begin
         r_pipe_stall <= (w_next_state == ST_FORCE);
         if (w_buf_loses) begin
            if (r_starve != STARVE_TOP) r_starve <= r_starve + 1'b1;
         end else begin
            r_starve <= '0;
         end
         // Register x0 still consumes its grant but never writes.
         if (w_grant_pipe) begin
            r_reg_wew <= (pipe_rd != '0);
            r_rdw     <= pipe_rd;
            r_result  <= pipe_data;
         end else if (w_pop) begin
            r_reg_wew <= (w_head_rd != '0);
            r_rdw     <= w_head_rd;
            r_result  <= w_head_data;
         end else begin
            r_reg_wew <= 1'b0;
         end
      end
   end

   assign pipe_stall = r_pipe_stall;
   assign reg_wew    = r_reg_wew;
   assign rdw        = r_rdw;
   assign result     = r_result;

endmodule
